// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Multi-cycle fetch/execute sequencer. Owns the program counter,
//            fetches instructions over a request/ready memory handshake and
//            applies the branch/jump next-PC rules when an instruction
//            retires.
// Ports    : clk, reset (async, active-high)
//            start, halt_req, stall              - run control
//            branch, zero, jump                  - decode/ALU flags (EXEC)
//            imem_ready, imem_rdata              - memory response
//            imem_req, imem_addr                 - memory request
//            instr, instr_valid, pc, busy        - sequencer state
//            fetch_err, retired_count            - status
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_count
);

  // The timeout counter only needs to reach FETCH_TIMEOUT-1.
  localparam int unsigned c_TCNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [c_TCNT_W-1:0] c_TO_LAST = c_TCNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [31:0]         r_pc;
  logic [31:0]         r_instr;
  logic                r_fetch_err;
  logic [CNT_W-1:0]    r_retired;
  logic [c_TCNT_W-1:0] r_tcnt;

  logic [31:0] w_pc_inc;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;
  logic [31:0] w_npc;

  // Next-PC datapath, identical to the single-cycle core's rules.
  assign w_pc_inc  = r_pc + 32'd4;
  assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_tgt  = w_pc_inc + w_br_off;
  assign w_jmp_tgt = {4'b0000, r_instr[25:0], 2'b00};
  assign w_npc     = jump            ? w_jmp_tgt :
                     (branch & zero) ? w_br_tgt  :
                                       w_pc_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_fetch_err <= 1'b0;
      r_retired   <= '0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // A response on the last allowed cycle still wins over the timeout.
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_tcnt  <= '0;
            r_state <= S_EXEC;
          end else if (r_tcnt == c_TO_LAST) begin
            r_fetch_err <= 1'b1;
            r_tcnt      <= '0;
            r_state     <= S_HALT;
          end else begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
          end
        end
        S_EXEC: begin
          // Stall freezes everything; halt_req is only looked at on retire.
          if (!stall) begin
            r_pc      <= w_npc;
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= halt_req ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          if (start) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req      = (r_state == S_FETCH);
  assign imem_addr     = r_pc;
  assign instr         = r_instr;
  assign instr_valid   = (r_state == S_EXEC);
  assign pc            = r_pc;
  assign busy          = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign fetch_err     = r_fetch_err;
  assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Purpose  : Self-checking bench for pc_fetch_sequencer. Directed stimulus
//            pushes the expected pc/retire count of every new fetch into a
//            scoreboard queue; a monitor pops and compares when a fetch
//            request begins. A second instance with a 4-bit retire counter
//            shares the stimulus to exercise counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start, halt_req, stall, branch, zero, jump, imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, busy, fetch_err;
  logic [31:0] imem_addr, instr, pc;
  logic [15:0] retired_count;

  logic        s_imem_req, s_instr_valid, s_busy, s_fetch_err;
  logic [31:0] s_imem_addr, s_instr, s_pc;
  logic [3:0]  s_retired;

  pc_fetch_sequencer u_dut (
    .clk(clk), .reset(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .branch(branch), .zero(zero), .jump(jump), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .fetch_err(fetch_err), .retired_count(retired_count)
  );

  pc_fetch_sequencer #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .reset(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .branch(branch), .zero(zero), .jump(jump), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_req(s_imem_req), .imem_addr(s_imem_addr),
    .instr(s_instr), .instr_valid(s_instr_valid), .pc(s_pc), .busy(s_busy),
    .fetch_err(s_fetch_err), .retired_count(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;
  logic mon_prev_req = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] p, input int c);
    exp_t e;
    e.pc  = p;
    e.cnt = c;
    sb_q.push_back(e);
  endtask

  // Monitor: compares the scoreboard head on the first cycle of each fetch.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && !mon_prev_req) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_fetch: got fetch at %h expected none", imem_addr);
        end else begin
          mon_e = sb_q.pop_front();
          chk("fetch_pc",      pc,                      mon_e.pc);
          chk("fetch_addr",    imem_addr,               mon_e.pc);
          chk("fetch_retired", {16'd0, retired_count},  32'(mon_e.cnt) & 32'h0000_FFFF);
          chk("fetch_pc_w4",   s_pc,                    mon_e.pc);
          chk("fetch_ret_w4",  {28'd0, s_retired},      32'(mon_e.cnt) & 32'h0000_000F);
        end
      end
      mon_prev_req = imem_req;
    end
  end

  // Called at a negedge while idle/halted; returns at the first FETCH negedge.
  task automatic do_start(input logic [31:0] exp_pc);
    start = 1'b1;
    sb_push(exp_pc, exp_cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge in EXEC: retire with the given flags.
  task automatic retire(input logic br, input logic z, input logic jp,
                        input logic [31:0] npc, input logic hlt);
    branch   = br;
    zero     = z;
    jump     = jp;
    halt_req = hlt;
    exp_cnt++;
    if (!hlt) sb_push(npc, exp_cnt);
    @(negedge clk);
    branch   = 1'b0;
    zero     = 1'b0;
    jump     = 1'b0;
    halt_req = 1'b0;
  endtask

  // Called at a negedge in FETCH with a one-cycle memory response.
  task automatic exec_one(input logic [31:0] ins, input logic br, input logic z,
                          input logic jp, input logic [31:0] npc);
    imem_rdata = ins;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("exec_instr", instr, ins);
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    retire(br, z, jp, npc, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},      pc,                     32'd0);
    chk({tag, "_instr"},   instr,                  32'd0);
    chk({tag, "_valid"},   {31'd0, instr_valid},   32'd0);
    chk({tag, "_req"},     {31'd0, imem_req},      32'd0);
    chk({tag, "_busy"},    {31'd0, busy},          32'd0);
    chk({tag, "_err"},     {31'd0, fetch_err},     32'd0);
    chk({tag, "_retired"}, {16'd0, retired_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    imem_ready = 1'b0; imem_rdata = NOP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Sequential NOPs, 2 cycles per instruction.
    do_start(32'h0);
    exec_one(NOP, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    exec_one(NOP, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    exec_one(NOP, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
    // Jump wins over a taken branch.
    exec_one(32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    // Backward branch taken, then not taken.
    exec_one(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'h0000_00FC);
    exec_one(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
    exec_one(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0104);
    exec_one(32'h0800_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    exec_one(32'h1000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_0110);
    // Jump to 0, branch to 0xFFFFFFFC, then pc+4 wraps to 0.
    exec_one(32'h0800_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    exec_one(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    exec_one(NOP,           1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Stall for 3 EXEC cycles with halt_req joining on the last one.
    imem_rdata = 32'h0800_0040;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    stall = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) halt_req = 1'b1;
      @(negedge clk);
      chk("stall_valid",   {31'd0, instr_valid},   32'd1);
      chk("stall_pc",      pc,                     32'h0);
      chk("stall_retired", {16'd0, retired_count}, 32'd12);
    end
    stall = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    retire(1'b0, 1'b0, 1'b0, 32'h4, 1'b1);
    chk("halt_busy",    {31'd0, busy},          32'd0);
    chk("halt_valid",   {31'd0, instr_valid},   32'd0);
    chk("halt_pc",      pc,                     32'h4);
    chk("halt_retired", {16'd0, retired_count}, 32'd13);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    chk("halt_hold_pc",   pc,                32'h4);
    chk("halt_hold_busy", {31'd0, busy},     32'd0);
    do_start(32'h4);
    exec_one(NOP, 1'b0, 1'b0, 1'b0, 32'h8);

    // Response on the 16th FETCH cycle is a success.
    imem_ready = 1'b0;
    repeat (15) @(negedge clk);
    chk("late16_req", {31'd0, imem_req},  32'd1);
    chk("late16_err", {31'd0, fetch_err}, 32'd0);
    imem_rdata = NOP;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("late16_valid",    {31'd0, instr_valid}, 32'd1);
    chk("late16_err_exec", {31'd0, fetch_err},   32'd0);
    retire(1'b0, 1'b0, 1'b0, 32'hC, 1'b0);

    // No response for 16 FETCH cycles: timeout to HALT.
    repeat (15) @(negedge clk);
    chk("to_req_last", {31'd0, imem_req},  32'd1);
    chk("to_err_last", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("to_err",  {31'd0, fetch_err}, 32'd1);
    chk("to_busy", {31'd0, busy},      32'd0);
    chk("to_req",  {31'd0, imem_req},  32'd0);
    chk("to_pc",   pc,                 32'hC);
    do_start(32'hC);
    exec_one(NOP, 1'b0, 1'b0, 1'b0, 32'h10);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("w4_wrap",    {28'd0, s_retired}, 32'd0);

    // Asynchronous reset in the middle of EXEC.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("pre_rst_exec_pc", pc, 32'h10);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_exec");
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-FETCH with a late response that must be ignored.
    do_start(32'h0);
    #3;
    rst = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1'b1;
    #1 chk_reset_outputs("rst_fetch");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("late_instr", instr,                 32'd0);
      chk("late_valid", {31'd0, instr_valid},  32'd0);
      chk("late_req",   {31'd0, imem_req},     32'd0);
    end
    imem_ready = 1'b0;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle fetch/execute sequencer that owns the program counter and sequences instruction fetch from a handshaked instruction memory. It replaces the free-running per-clock PC update with a controlled FSM that supports start, stall, halt and fetch timeout. The next-PC rules for branch and jump match the core's single-cycle PC datapath. It sits between the instruction memory port and the decode/control unit, which supplies branch, jump and zero.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FETCH_TIMEOUT, 16, max cycles in FETCH waiting for imem_ready before error (≥1).
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  leave IDLE/HALT and begin fetching at current pc.
halt_req  in  1  sampled in EXEC; go to HALT after the current instruction retires.
stall  in  1  hold EXEC (no retire, no pc update).
branch  in  1  decoded branch, valid in EXEC.
zero  in  1  ALU zero flag, valid in EXEC.
jump  in  1  decoded jump, valid in EXEC.
imem_ready  in  1  memory has valid imem_rdata this cycle.
imem_rdata  in  32  fetched instruction word.
imem_req  out  1  fetch request, high throughout FETCH.
imem_addr  out  32  fetch address (= pc).
instr  out  32  latched instruction.
instr_valid  out  1  high in EXEC.
pc  out  32  current program counter.
busy  out  1  high in FETCH or EXEC.
fetch_err  out  1  sticky timeout flag.
retired_count  out  CNT_W  instructions retired, wraps.

Behaviour:
- Reset (async, any state, mid-fetch included): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, retired_count=0, timeout counter=0. Any outstanding memory response is ignored.
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered or decoded from state only. imem_req=(state==FETCH). imem_addr=pc.
- IDLE: when start=1, go to FETCH next cycle. Otherwise stay.
- FETCH: the timeout counter increments each cycle.
  - If imem_ready=1: latch instr<=imem_rdata, clear the counter, go to EXEC.
  - Else, if the counter reaches FETCH_TIMEOUT-1: set fetch_err=1, go to HALT, leave pc unchanged.
  - imem_ready on the same cycle as the last timeout cycle counts as success; there is no error.
  - Minimum fetch latency is 1 cycle (imem_ready in the first FETCH cycle).
- EXEC: instr_valid=1.
  - If stall=1: hold and ignore all other inputs.
  - Else (retire): pc<=npc and retired_count<=retired_count+1, mod 2^CNT_W. Then go to HALT if halt_req=1, otherwise to FETCH.
- npc (32-bit, wrap mod 2^32):
  - pc_inc=pc+4.
  - br_tgt = pc_inc + (signext(instr[15:0])<<2).
  - jmp_tgt = {4'b0, instr[25:0], 2'b00}.
  - Priority: jump=1 → jmp_tgt. Else branch&zero → br_tgt. Else pc_inc.
- HALT: busy=0, pc held. start=1 → FETCH, resuming at the held pc. fetch_err stays set until reset.
- start in FETCH/EXEC is ignored. halt_req outside EXEC is ignored; it is not queued.
- stall and halt_req together in EXEC: stall wins; halt_req is re-sampled on the retire cycle.
- Steady state with no stalls and single-cycle memory: 2 cycles per instruction.

Test Plan:
- Reset, start, imem_ready always 1, rdata=NOP, no branch/jump → pc goes 0,4,8,12 every 2 cycles. retired_count=3 after 6 cycles in run. imem_addr tracks pc.
- Branch taken: pc=0x100, instr[15:0]=16'hFFFE, branch=1, zero=1 → pc=0x0FC. Same with zero=0 → pc=0x104. imm=16'h0003 → pc=0x110.
- Jump priority: instr[25:0]=26'h0000040, jump=1, branch=1, zero=1 → pc=0x100. Wrap check: pc=0xFFFF_FFFC with no branch → pc=0x0.
- Stall: stall high for 3 EXEC cycles → instr_valid held, pc and retired_count unchanged, and they update in the cycle after stall drops. stall+halt_req asserted, then stall released with halt_req=1 → HALT, busy=0. Then start → resumes at the next pc.
- Timeout: FETCH_TIMEOUT=16, imem_ready held 0 → fetch_err=1 and state HALT after 16 FETCH cycles, pc unchanged. Ready on cycle 16 → no error.
- Async reset asserted mid-FETCH and mid-EXEC (not clock-aligned) → all outputs at reset values immediately. A late imem_ready after reset is ignored. retired_count wraps 0xFFFF→0x0000.
